ifu_prefetch: RTL and testbench

Instruction-fetch unit feeding the `if_id` pipeline register. It issues word-aligned instruction reads on the instruction bus and keeps up to DEPTH requests in flight. Returned instructions are queued with their addresses, and the queue head is presented to `if_id` each cycle. Jumps from `ex` redirect fetch, flush the queue and discard stale in-flight responses.

---
 rtl/ifu_prefetch_pkg.sv | 36 +++
 rtl/ifu_prefetch_ifq_fifo.sv | 72 +++++++
 rtl/ifu_prefetch.sv | 123 ++++++++++++
 tb/tb_ifu_prefetch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and types for the instruction prefetch unit.
package ifu_prefetch_pkg;

    localparam int IfqDepth = 4;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam logic RstEnable  = 1'b0;
    localparam logic RstDisable = 1'b1;

    // Pipeline hold codes from ctrl, ordered by how much of the pipe they stall.
    typedef enum logic [2:0] {
        HoldNone = 3'b000,
        HoldPc   = 3'b001,
        HoldIf   = 3'b010,
        HoldId   = 3'b011
    } hold_flag_e;

    localparam logic [2:0] Hold_None = 3'b000;
    localparam logic [2:0] Hold_Pc   = 3'b001;
    localparam logic [2:0] Hold_If   = 3'b010;
    localparam logic [2:0] Hold_Id   = 3'b011;

    // One queued instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } ifq_entry_t;

    // Next sequential word address, wrapping at 32 bits.
    function automatic logic [31:0] next_word(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifu_prefetch_ifq_fifo.sv
// Small synchronous FIFO with flush, used for both the instruction queue and
// the issued-address tracker of the prefetch unit.
module ifq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    import ifu_prefetch_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_eff, pop_eff;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[head_q];

    // Qualify requests: a flush wins, pops need data, pushes need room.
    always_comb begin
        pop_eff  = pop_i && !empty_o && !flush_i;
        push_eff = push_i && !flush_i && (!full_o || pop_eff);
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(pop_eff);
            tail_d  = tail_q + AW'(push_eff);
            count_d = count_q + CW'(push_eff) - CW'(pop_eff);
        end
    end

    // Storage is written only on an accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[tail_q] <= wdata_i;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: keeps up to DEPTH reads in flight, queues the
// returned words with their addresses and presents the head to if_id.
module ifu_prefetch #(
    parameter int          DEPTH    = ifu_prefetch_pkg::IfqDepth,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [2:0]  hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);
    import ifu_prefetch_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = AW + 3;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [SW-1:0] credit_sum;
    logic          fire, drop, keep;
    logic          q_push, q_pop, aq_push, aq_pop;

    ifq_entry_t    q_wdata, q_rdata;
    logic [CW-1:0] q_count, aq_count;
    logic          q_empty, q_full, aq_empty, aq_full;
    logic [31:0]   aq_rdata;
    logic          unused_fifo_status;

    assign unused_fifo_status = ^{q_full, aq_count, aq_empty, aq_full};

    // Credit check, response classification and queue controls.
    always_comb begin
        credit_sum = SW'(q_count) + SW'(inflight_q) + SW'(discard_q);
        ibus_req_o = (rst == RstDisable) && (hold_flag_i < Hold_Pc) &&
                     !jump_flag_i && (credit_sum < SW'(DEPTH));
        fire       = ibus_req_o && ibus_gnt_i;
        drop       = ibus_rvalid_i && (discard_q != '0);
        keep       = ibus_rvalid_i && (discard_q == '0);
        q_push     = keep && !jump_flag_i;
        q_pop      = (hold_flag_i < Hold_If) && !q_empty && !jump_flag_i;
        aq_push    = fire;
        aq_pop     = keep && !jump_flag_i;
        q_wdata    = '{addr: aq_rdata, inst: ibus_rdata_i};
    end

    // Next fetch address and in-flight/stale-response bookkeeping.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        if (jump_flag_i) begin
            fetch_pc_d = jump_addr_i;
            inflight_d = '0;
            discard_d  = discard_q + inflight_q + CW'(fire) - CW'(ibus_rvalid_i);
        end else begin
            if (fire) begin
                fetch_pc_d = next_word(fetch_pc_q);
            end
            inflight_d = inflight_q + CW'(fire) - CW'(keep);
            discard_d  = discard_q - CW'(drop);
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    ifq_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_inst_q (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (jump_flag_i),
        .wdata_i (q_wdata),
        .rdata_o (q_rdata),
        .count_o (q_count),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    ifq_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_addr_q (
        .clk     (clk),
        .rst     (rst),
        .push_i  (aq_push),
        .pop_i   (aq_pop),
        .flush_i (jump_flag_i),
        .wdata_i (fetch_pc_q),
        .rdata_o (aq_rdata),
        .count_o (aq_count),
        .empty_o (aq_empty),
        .full_o  (aq_full)
    );

    // Head of queue towards if_id; hidden during a redirect.
    always_comb begin
        ibus_addr_o  = fetch_pc_q;
        inst_valid_o = !q_empty && !jump_flag_i;
        inst_o       = inst_valid_o ? q_rdata.inst : INST_NOP;
        inst_addr_o  = inst_valid_o ? q_rdata.addr : ZeroWord;
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: a queue-level model of the fetch unit
// and an in-order instruction bus, checked every cycle, plus pinned literals.
module tb_ifu_prefetch;
    import ifu_prefetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic [2:0]  hold_flag_i = 3'b0;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i = 1'b0;
    logic        ibus_rvalid_i = 1'b0;
    logic [31:0] ibus_rdata_i = 32'h0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .hold_flag_i   (hold_flag_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } busEntry_t;

    busEntry_t   busQ[$];
    logic [31:0] mQ[$];
    logic [31:0] mPc = RESET_PC;
    int          cycle = 0;
    int          busLat = 1;
    bit          rstNext = 1'b0;
    bit          checkEn = 1'b0;

    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInst;
    logic [31:0] expIaddr;

    int checks = 0;
    int errors = 0;

    // Memory contents seen through the bus: a fixed function of the address.
    function automatic logic [31:0] instFor(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Every outstanding bus transaction plus every queued word uses one credit.
    function automatic bit modelReq(input logic [2:0] hold, input bit jump);
        return (rst == 1'b1) && (hold < Hold_Pc) && !jump &&
               ((mQ.size() + busQ.size()) < DEPTH);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    // Advance the model over the edge that ends the current cycle.
    task automatic modelUpdate();
        bit        jmp;
        bit        fire;
        busEntry_t e;
        if (rst == 1'b1) begin
            jmp  = jump_flag_i;
            fire = modelReq(hold_flag_i, jmp) && ibus_gnt_i;
            if (!jmp && hold_flag_i < Hold_If && mQ.size() > 0) begin
                void'(mQ.pop_front());
            end
            if (ibus_rvalid_i) begin
                e = busQ.pop_front();
                if (!e.stale && !jmp) begin
                    mQ.push_back(e.addr);
                end
            end
            if (jmp) begin
                mQ.delete();
                foreach (busQ[i]) busQ[i].stale = 1'b1;
                mPc = jump_addr_i;
            end
            if (fire) begin
                busQ.push_back('{addr: mPc, due: cycle + busLat, stale: 1'b0});
                mPc = mPc + 32'd4;
            end
        end
        cycle++;
    endtask

    // One clock cycle: close the previous cycle, drive new inputs, set expectations.
    task automatic applyStimulus(input logic [2:0] hold, input bit jump,
                                 input logic [31:0] jaddr, input bit gnt);
        @(posedge clk);
        modelUpdate();
        #1;
        rst = rstNext;
        if (!rstNext) begin
            mQ.delete();
            busQ.delete();
            mPc = RESET_PC;
        end
        hold_flag_i = hold;
        jump_flag_i = jump;
        jump_addr_i = jaddr;
        ibus_gnt_i  = gnt;
        if (rstNext && busQ.size() > 0 && busQ[0].due <= cycle) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = instFor(busQ[0].addr);
        end else begin
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = 32'h0;
        end
        expReq   = modelReq(hold, jump);
        expAddr  = mPc;
        expValid = (mQ.size() > 0) && !jump;
        expInst  = expValid ? instFor(mQ[0]) : INST_NOP;
        expIaddr = expValid ? mQ[0] : ZeroWord;
        checkEn  = 1'b1;
        @(negedge clk);
    endtask

    // Compare DUT against the model on every cycle.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("req",        32'(ibus_req_o),   32'(expReq));
            checkOutput("ibus_addr",  ibus_addr_o,       expAddr);
            checkOutput("inst_valid", 32'(inst_valid_o), 32'(expValid));
            checkOutput("inst",       inst_o,            expInst);
            checkOutput("inst_addr",  inst_addr_o,       expIaddr);
        end
    end

    // Run until the first valid head appears and pin its address.
    task automatic expectFirstHead(input string name, input logic [31:0] target);
        bit found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
            if (inst_valid_o) begin
                found = 1'b1;
                checkOutput(name, inst_addr_o, target);
            end
        end
        if (!found) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic [31:0] drainExp [4] = '{32'h18, 32'h1C, 32'h20, 32'h24};
    logic [2:0]  mixHold  [10] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd2, 3'd0, 3'd1, 3'd0, 3'd0, 3'd3};
    bit          mixGnt   [10] = '{1, 0, 1, 1, 1, 0, 1, 1, 0, 1};

    initial begin
        // Reset held for two cycles.
        rstNext = 1'b0;
        applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
        applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
        checkOutput("rst_req",   32'(ibus_req_o),   32'd0);
        checkOutput("rst_addr",  ibus_addr_o,       RESET_PC);
        checkOutput("rst_inst",  inst_o,            32'h0000_0013);
        checkOutput("rst_iaddr", inst_addr_o,       32'h0);
        checkOutput("rst_valid", 32'(inst_valid_o), 32'd0);

        // Streaming fetch with gnt tied high and one-cycle response latency.
        rstNext = 1'b1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
            if (k == 0) begin
                checkOutput("first_req",  32'(ibus_req_o), 32'd1);
                checkOutput("first_addr", ibus_addr_o,     32'h0);
            end
            if (k == 1) checkOutput("second_addr", ibus_addr_o, 32'h4);
            if (k == 2) begin
                checkOutput("first_inst",  inst_o,      32'hC0DE_0000);
                checkOutput("first_iaddr", inst_addr_o, 32'h0);
            end
            if (k == 3) checkOutput("second_iaddr", inst_addr_o, 32'h4);
        end

        // Hold at Hold_If: queue fills to DEPTH, head frozen, then drains in order.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(Hold_If, 1'b0, 32'h0, 1'b1);
            if (k == 3) checkOutput("hold_req_stop", 32'(ibus_req_o), 32'd0);
            if (k == 4) begin
                checkOutput("hold_iaddr", inst_addr_o, 32'h18);
                checkOutput("hold_inst",  inst_o,      32'hC0DE_0018);
            end
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
            checkOutput("drain_iaddr", inst_addr_o, drainExp[k]);
        end

        // Redirect with several requests in flight (longer bus latency).
        busLat = 3;
        for (int k = 0; k < 5; k++) applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
        applyStimulus(Hold_None, 1'b1, 32'h100, 1'b1);
        checkOutput("jump_valid", 32'(inst_valid_o), 32'd0);
        checkOutput("jump_inst",  inst_o,            32'h0000_0013);
        applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
        checkOutput("redirect_addr", ibus_addr_o, 32'h100);
        expectFirstHead("jump_head", 32'h100);

        // Redirect in the same cycle as a response.
        busLat = 1;
        for (int k = 0; k < 6; k++) applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
        applyStimulus(Hold_None, 1'b1, 32'h200, 1'b1);
        expectFirstHead("jump_rv_head", 32'h200);

        // Delayed grant after a fresh reset.
        rstNext = 1'b0;
        applyStimulus(Hold_None, 1'b0, 32'h0, 1'b0);
        rstNext = 1'b1;
        applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
        applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(Hold_None, 1'b0, 32'h0, 1'b0);
            checkOutput("gnt_wait_addr", ibus_addr_o,     32'h8);
            checkOutput("gnt_wait_req",  32'(ibus_req_o), 32'd1);
        end
        applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
        checkOutput("gnt_addr", ibus_addr_o, 32'h8);
        applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
        checkOutput("gnt_next_addr", ibus_addr_o, 32'hC);

        // Mixed holds and grant gaps with two-cycle latency.
        busLat = 2;
        for (int k = 0; k < 10; k++) applyStimulus(mixHold[k], 1'b0, 32'h0, mixGnt[k]);

        // Mid-operation reset with entries queued and in flight.
        for (int k = 0; k < 3; k++) applyStimulus(Hold_If, 1'b0, 32'h0, 1'b1);
        rstNext = 1'b0;
        applyStimulus(Hold_If, 1'b0, 32'h0, 1'b1);
        checkOutput("midrst_inst",  inst_o,            32'h0000_0013);
        checkOutput("midrst_iaddr", inst_addr_o,       32'h0);
        checkOutput("midrst_valid", 32'(inst_valid_o), 32'd0);
        checkOutput("midrst_req",   32'(ibus_req_o),   32'd0);
        applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
        rstNext = 1'b1;
        applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);
        checkOutput("restart_addr", ibus_addr_o,     RESET_PC);
        checkOutput("restart_req",  32'(ibus_req_o), 32'd1);
        for (int k = 0; k < 6; k++) applyStimulus(Hold_None, 1'b0, 32'h0, 1'b1);

        checkEn = 1'b0;
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
